number_decoder: RTL and testbench

Combinational-core, single-register-stage decoder that turns a JPEG entropy-coded magnitude (variable-length "additional bits" following a Huffman symbol) into a signed two's-complement coefficient value. It sits in the JPEG decode pipeline after the Huffman/run-length stage, which supplies the size category and raw bits. It feeds the dequantiser with an 8-bit signed value, one result per accepted input.

---
 rtl/number_decoder.sv | 92 +++++++++
 tb/tb_number_decoder.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/number_decoder.sv
// JPEG magnitude decoder: turns a size category plus raw additional bits into an 8-bit signed coefficient, one register stage.
// Optional clamping of out-of-range results is enabled by defining NUMBER_DECODER_SATURATE_EN.
module number_decoder (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    input  logic [3:0]  r_value,
    input  logic [11:0] coded_number,
    output logic        out_valid,
    output logic [7:0]  decoded_number,
    output logic        overflow,
    output logic        range_err
);

    logic               outValid_q,   outValid_d;
    logic [7:0]         decodedNum_q, decodedNum_d;
    logic               overflow_q,   overflow_d;
    logic               rangeErr_q,   rangeErr_d;

    logic [11:0]        catMask;
    logic [11:0]        maskedNum;
    logic [11:0]        topBit;
    logic               isPositive;
    logic signed [12:0] fullValue;
    logic               outOfRange;
    logic [7:0]         narrowValue;

    // A clear top bit marks a negative value stored as m + (2^r - 1).
    always_comb begin
        catMask    = 12'((13'd1 << r_value) - 13'd1);
        maskedNum  = coded_number & catMask;
        topBit     = 12'((13'd1 << r_value) >> 1);
        isPositive = |(maskedNum & topBit);
        if (r_value == 4'd0) begin
            fullValue = 13'sd0;
        end else if (isPositive) begin
            fullValue = $signed({1'b0, maskedNum});
        end else begin
            fullValue = $signed({1'b0, maskedNum}) - $signed({1'b0, catMask});
        end
        outOfRange = (fullValue > 13'sd127) || (fullValue < -13'sd128);
`ifdef NUMBER_DECODER_SATURATE_EN
        if (!outOfRange) begin
            narrowValue = fullValue[7:0];
        end else if (fullValue[12]) begin
            narrowValue = 8'h80;
        end else begin
            narrowValue = 8'h7F;
        end
`else
        narrowValue = fullValue[7:0];
`endif
    end

    always_comb begin
        outValid_d   = in_valid;
        decodedNum_d = decodedNum_q;
        overflow_d   = overflow_q;
        rangeErr_d   = rangeErr_q;
        if (in_valid) begin
            if (r_value > 4'd11) begin
                decodedNum_d = 8'h00;
                overflow_d   = 1'b0;
                rangeErr_d   = 1'b1;
            end else begin
                decodedNum_d = narrowValue;
                overflow_d   = outOfRange;
                rangeErr_d   = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            outValid_q   <= 1'b0;
            decodedNum_q <= 8'h00;
            overflow_q   <= 1'b0;
            rangeErr_q   <= 1'b0;
        end else begin
            outValid_q   <= outValid_d;
            decodedNum_q <= decodedNum_d;
            overflow_q   <= overflow_d;
            rangeErr_q   <= rangeErr_d;
        end
    end

    assign out_valid      = outValid_q;
    assign decoded_number = decodedNum_q;
    assign overflow       = overflow_q;
    assign range_err      = rangeErr_q;

endmodule

// File: tb/tb_number_decoder.sv
// Self-checking bench for number_decoder: directed vectors, random stream and reset scenarios against a scoreboard.
module tb_number_decoder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic [3:0]  r_value;
    logic [11:0] coded_number;
    logic        out_valid;
    logic [7:0]  decoded_number;
    logic        overflow;
    logic        range_err;

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic [7:0] d;
        logic       o;
        logic       e;
    } exp_t;

    typedef struct packed {
        logic        v;
        logic [3:0]  r;
        logic [11:0] c;
        exp_t        x;
    } vec_t;

    exp_t scoreboard[$];
    exp_t lastExp;

    number_decoder dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .in_valid       (in_valid),
        .r_value        (r_value),
        .coded_number   (coded_number),
        .out_valid      (out_valid),
        .decoded_number (decoded_number),
        .overflow       (overflow),
        .range_err      (range_err)
    );

    always #5 clk = ~clk;

    function automatic exp_t model(int r, int c);
        exp_t res;
        int m, v;
        res = '0;
        if (r > 11) begin
            res.e = 1'b1;
            return res;
        end
        m = c % (1 << r);
        if (r == 0)                 v = 0;
        else if (m >= (1 << (r-1))) v = m;
        else                        v = m - ((1 << r) - 1);
        res.o = (v < -128) || (v > 127);
`ifdef NUMBER_DECODER_SATURATE_EN
        if (!res.o)     res.d = 8'(v);
        else if (v < 0) res.d = 8'h80;
        else            res.d = 8'h7F;
`else
        res.d = 8'(v);
`endif
        return res;
    endfunction

    function automatic vec_t mkVec(logic v, logic [3:0] r, logic [11:0] c,
                                   logic [7:0] d, logic o, logic e);
        vec_t t;
        t.v = v; t.r = r; t.c = c;
        t.x.d = d; t.x.o = o; t.x.e = e;
        return t;
    endfunction

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b1; r_value = 4'd1; coded_number = 12'h001;
        repeat (2) @(negedge clk);
        rst_n = 1'b1; in_valid = 1'b0;
        @(negedge clk);
        total++;
        if (out_valid !== 1'b0 || decoded_number !== 8'h00 || overflow !== 1'b0 || range_err !== 1'b0) begin
            bad++;
            $display("[TB] FAIL reset_idle got v=%b d=%h o=%b e=%b want v=0 d=00 o=0 e=0",
                     out_valid, decoded_number, overflow, range_err);
        end
        lastExp = '0;
    endtask

    task automatic test_vectors();
        vec_t vecs[$];
        exp_t want;
        logic [7:0] ovNegD, ovPosD, ovP128D;
`ifdef NUMBER_DECODER_SATURATE_EN
        ovNegD = 8'h80; ovPosD = 8'h7F; ovP128D = 8'h7F;
`else
        ovNegD = 8'h01; ovPosD = 8'hFF; ovP128D = 8'h80;
`endif
        vecs.push_back(mkVec(1'b1, 4'd1,  12'h000, 8'hFF, 1'b0, 1'b0));
        vecs.push_back(mkVec(1'b1, 4'd2,  12'h000, 8'hFD, 1'b0, 1'b0));
        vecs.push_back(mkVec(1'b1, 4'd1,  12'h001, 8'h01, 1'b0, 1'b0));
        vecs.push_back(mkVec(1'b1, 4'd2,  12'h001, 8'hFE, 1'b0, 1'b0));
        vecs.push_back(mkVec(1'b1, 4'd4,  12'h005, 8'hF6, 1'b0, 1'b0));
        vecs.push_back(mkVec(1'b1, 4'd4,  12'hFF5, 8'hF6, 1'b0, 1'b0));
        vecs.push_back(mkVec(1'b1, 4'd0,  12'hABC, 8'h00, 1'b0, 1'b0));
        vecs.push_back(mkVec(1'b1, 4'd7,  12'h07F, 8'h7F, 1'b0, 1'b0));
        vecs.push_back(mkVec(1'b1, 4'd8,  12'h000, ovNegD, 1'b1, 1'b0));
        vecs.push_back(mkVec(1'b1, 4'd8,  12'h0FF, ovPosD, 1'b1, 1'b0));
        vecs.push_back(mkVec(1'b1, 4'd8,  12'h07F, 8'h80, 1'b0, 1'b0));
        vecs.push_back(mkVec(1'b1, 4'd8,  12'h080, ovP128D, 1'b1, 1'b0));
        vecs.push_back(mkVec(1'b1, 4'd12, 12'h800, 8'h00, 1'b0, 1'b1));
        vecs.push_back(mkVec(1'b1, 4'd1,  12'h001, 8'h01, 1'b0, 1'b0));
        vecs.push_back(mkVec(1'b1, 4'd15, 12'hFFF, 8'h00, 1'b0, 1'b1));
        vecs.push_back(mkVec(1'b1, 4'd3,  12'h004, 8'h04, 1'b0, 1'b0));
        vecs.push_back(mkVec(1'b0, 4'd5,  12'h001, 8'h00, 1'b0, 1'b0));
        vecs.push_back(mkVec(1'b1, 4'd3,  12'h003, 8'hFC, 1'b0, 1'b0));
        foreach (vecs[i]) begin
            in_valid = vecs[i].v; r_value = vecs[i].r; coded_number = vecs[i].c;
            if (vecs[i].v) scoreboard.push_back(vecs[i].x);
            @(negedge clk);
            total++;
            if (out_valid !== vecs[i].v) begin
                bad++;
                $display("[TB] FAIL vec%0d out_valid got %b want %b", i, out_valid, vecs[i].v);
            end
            if (vecs[i].v) want = scoreboard.pop_front();
            else           want = lastExp;
            total++;
            if (decoded_number !== want.d || overflow !== want.o || range_err !== want.e) begin
                bad++;
                $display("[TB] FAIL vec%0d r=%0d c=%h got d=%h o=%b e=%b want d=%h o=%b e=%b",
                         i, vecs[i].r, vecs[i].c, decoded_number, overflow, range_err, want.d, want.o, want.e);
            end
            lastExp = want;
        end
        in_valid = 1'b0;
    endtask

    task automatic test_back_to_back();
        exp_t want;
        logic       v;
        logic [3:0] r;
        logic [11:0] c;
        for (int i = 0; i < 60; i++) begin
            v = (i % 7 != 3);
            r = 4'($urandom_range(0, 15));
            c = 12'($urandom_range(0, 4095));
            in_valid = v; r_value = r; coded_number = c;
            if (v) scoreboard.push_back(model(int'(r), int'(c)));
            @(negedge clk);
            total++;
            if (out_valid !== v) begin
                bad++;
                $display("[TB] FAIL b2b%0d out_valid got %b want %b", i, out_valid, v);
            end
            want = v ? scoreboard.pop_front() : lastExp;
            total++;
            if (decoded_number !== want.d || overflow !== want.o || range_err !== want.e) begin
                bad++;
                $display("[TB] FAIL b2b%0d r=%0d c=%h got d=%h o=%b e=%b want d=%h o=%b e=%b",
                         i, r, c, decoded_number, overflow, range_err, want.d, want.o, want.e);
            end
            lastExp = want;
        end
        in_valid = 1'b0;
    endtask

    task automatic test_mid_reset();
        in_valid = 1'b1; r_value = 4'd1; coded_number = 12'h001;
        @(negedge clk);
        total++;
        if (out_valid !== 1'b1 || decoded_number !== 8'h01) begin
            bad++;
            $display("[TB] FAIL pre_reset got v=%b d=%h want v=1 d=01", out_valid, decoded_number);
        end
        rst_n = 1'b0; in_valid = 1'b1; r_value = 4'd8; coded_number = 12'h0FF;
        @(negedge clk);
        total++;
        if (out_valid !== 1'b0 || decoded_number !== 8'h00 || overflow !== 1'b0 || range_err !== 1'b0) begin
            bad++;
            $display("[TB] FAIL mid_reset got v=%b d=%h o=%b e=%b want v=0 d=00 o=0 e=0",
                     out_valid, decoded_number, overflow, range_err);
        end
        rst_n = 1'b1; in_valid = 1'b0;
        @(negedge clk);
        total++;
        if (out_valid !== 1'b0 || decoded_number !== 8'h00 || overflow !== 1'b0) begin
            bad++;
            $display("[TB] FAIL post_reset_idle got v=%b d=%h o=%b want v=0 d=00 o=0",
                     out_valid, decoded_number, overflow);
        end
        in_valid = 1'b1; r_value = 4'd2; coded_number = 12'h002;
        @(negedge clk);
        in_valid = 1'b0;
        total++;
        if (out_valid !== 1'b1 || decoded_number !== 8'h02 || range_err !== 1'b0) begin
            bad++;
            $display("[TB] FAIL first_after_reset got v=%b d=%h e=%b want v=1 d=02 e=0",
                     out_valid, decoded_number, range_err);
        end
        @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; r_value = 4'd0; coded_number = 12'h000;
        lastExp = '0;
        @(negedge clk);
        test_reset();
        test_vectors();
        test_back_to_back();
        test_mid_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
